// File: rtl/dff_shift_sequencer.sv
// rtl/dff_shift_sequencer.sv - parallel-in, serial-out shift sequencer with valid/ready intake and done pulse
module dff_shift_sequencer #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rest,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       abort,
    output logic                       in_ready,
    output logic                       sout,
    output logic                       sout_en,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH+1)-1:0] bit_idx
);

    localparam int BW = $clog2(WIDTH + 1);
    // A single-cycle bit period still needs a one-bit counter to keep the logic uniform.
    localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [BW-1:0]    bit_idx_q, bit_idx_d;

    logic             head_bit;
    logic             last_tick;
    logic [WIDTH-1:0] shreg_advanced;

    // Head bit selection and the one-step advance of the shift register toward the head.
    always_comb begin
        if (MSB_FIRST) begin
            head_bit       = shreg_q[WIDTH-1];
            shreg_advanced = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            head_bit       = shreg_q[0];
            shreg_advanced = {1'b0, shreg_q[WIDTH-1:1]};
        end
        last_tick = (tick_q == TW'(BIT_CYCLES - 1));
    end

    // Next-state logic: intake in IDLE, bit timing in SHIFT, single-cycle DONE, abort back to IDLE.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        tick_d    = tick_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            IDLE: begin
                // abort takes priority over an offered word
                if (in_valid && !abort) begin
                    state_d   = SHIFT;
                    shreg_d   = in_data;
                    tick_d    = '0;
                    bit_idx_d = '0;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d   = IDLE;
                    shreg_d   = '0;
                    tick_d    = '0;
                    bit_idx_d = '0;
                end else if (last_tick) begin
                    shreg_d   = shreg_advanced;
                    tick_d    = '0;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == BW'(WIDTH - 1)) begin
                        state_d = DONE;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            DONE: begin
                state_d   = IDLE;
                shreg_d   = '0;
                tick_d    = '0;
                bit_idx_d = '0;
            end
            default: begin
                state_d   = IDLE;
                shreg_d   = '0;
                tick_d    = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            tick_q    <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            tick_q    <= tick_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    // Outputs decoded from registered state only, so no input reaches an output combinationally.
    always_comb begin
        in_ready = (state_q == IDLE);
        sout_en  = (state_q == SHIFT);
        sout     = (state_q == SHIFT) ? head_bit : 1'b0;
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        bit_idx  = bit_idx_q;
    end

endmodule
